// File: rtl/opc5_uart.sv
// -----------------------------------------------------------------------------
// opc5_uart - memory-mapped 8N1 UART for the OPC5 CPU bus.
//
// A TX FIFO feeds a serialiser. An optional receive path has a deserialiser and
// a one-byte holding register. The top level muxes dout onto the CPU data bus
// whenever dout_en is high.
//
// Register window (BASE+3 and above are unmapped):
//   BASE+0 DATA    W: push din[7:0] into the TX FIFO
//                  R: {8'h00, rx_byte}; a read clears rx_valid
//   BASE+1 STATUS  R: {11'b0, frame_err, overrun, rx_valid, tx_empty, tx_full}
//                  W: din[3]=1 clears overrun, din[4]=1 clears frame_err
//   BASE+2 DIVISOR R/W; bit time = divisor+1 clocks; a write of 0 stores 1
//
// Build option: define OPC5_UART_RX_EN to build the receive path. Without it,
// rxd is ignored and the RX status bits and rx_byte read as zero.
//
// Ports:
//   clk      in   system clock, shared with the CPU
//   reset_b  in   synchronous active-low reset
//   address  in   [15:0] CPU address bus
//   rnw      in   CPU read-not-write (0 = store this cycle)
//   din      in   [15:0] CPU write data
//   dout     out  [15:0] read data, combinational from address (0 when not enabled)
//   dout_en  out  high on a read cycle that hits BASE..BASE+2
//   txd      out  serial output, idle high
//   rxd      in   serial input, asynchronous, idle high
// -----------------------------------------------------------------------------
module opc5_uart #(
    parameter logic [15:0] BASE        = 16'hFE00,
    parameter int          TX_DEPTH    = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] address,
    input  logic        rnw,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        dout_en,
    output logic        txd,
    input  logic        rxd
);

    localparam int            PW       = $clog2(TX_DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

    // A zero divisor would give no bit timing at all; clamp it to 1.
    function automatic logic [15:0] sat_div(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic sel_data;
    logic sel_stat;
    logic sel_div;

    assign sel_data = (address == BASE);
    assign sel_stat = (address == BASE + 16'd1);
    assign sel_div  = (address == BASE + 16'd2);
    assign dout_en  = rnw && (sel_data || sel_stat || sel_div);

    logic [15:0] div_q;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            div_q <= DEFAULT_DIV;
        end else if (!rnw && sel_div) begin
            div_q <= sat_div(din);
        end
    end

    // Receive-side results; driven by the RX path or tied off below.
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [7:0]    tx_mem [TX_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          tx_full;
    logic          tx_empty;

    // A push into a full FIFO is still accepted when the serialiser pops on
    // the same edge, because a slot frees up at that moment.
    assign tx_full = (count == FULL_CNT);
    assign push    = !rnw && sel_data && (!tx_full || pop);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tx_mem[wptr] <= din[7:0];
        end
    end

    // -------------------------------------------------------------------------
    // TX serialiser
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t   tx_state;
    tx_state_t   tx_next;
    logic [15:0] tx_timer;
    logic        tx_tick;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_shift;

    assign tx_tick  = (tx_timer == 16'd0);
    assign tx_empty = (count == '0) && (tx_state == TX_IDLE);

    always_comb begin
        tx_next  = tx_state;
        pop      = 1'b0;
        tx_shift = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shift = 1'b1;
                    if (tx_bit == 3'd7) begin
                        tx_next = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (tx_tick) begin
                    if (count != '0) begin
                        pop     = 1'b1;
                        tx_next = TX_START;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_next;
            // The divisor is sampled only at bit boundaries, so a write during
            // a frame never stretches or cuts the bit in progress.
            if (pop || (tx_state != TX_IDLE && tx_tick)) begin
                tx_timer <= div_q;
            end else if (!tx_tick) begin
                tx_timer <= tx_timer - 16'd1;
            end
            if (pop) begin
                tx_bit <= '0;
            end else if (tx_shift) begin
                tx_bit <= tx_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            tx_sh <= tx_mem[rptr];
        end else if (tx_shift) begin
            tx_sh <= {1'b0, tx_sh[7:1]};
        end
    end

    always_comb begin
        txd = 1'b1;
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_sh[0];
            default:  txd = 1'b1;
        endcase
    end

`ifdef OPC5_UART_RX_EN
    // -------------------------------------------------------------------------
    // RX deserialiser
    // -------------------------------------------------------------------------
    function automatic logic [15:0] half_bit(input logic [15:0] v);
        return 16'(({1'b0, v} + 17'd1) >> 1);
    endfunction

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic        rxd_p0;
    logic        rxd_p1;
    logic        rxd_p2;
    logic [15:0] rx_timer;
    logic        rx_tick;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_shift;
    logic        rx_done;
    logic        rd_data;
    logic        wr_stat;

    assign rx_tick = (rx_timer == 16'd0);
    assign rd_data = rnw && sel_data;
    assign wr_stat = !rnw && sel_stat;

    // Synchroniser stages p0/p1; p2 holds the previous value for edge detect.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    always_comb begin
        rx_next  = rx_state;
        rx_shift = 1'b0;
        rx_done  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rxd_p2 && !rxd_p1) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                // A high mid-start sample means a glitch, not a frame.
                if (rx_tick) begin
                    rx_next = rxd_p1 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift = 1'b1;
                    if (rx_bit == 3'd7) begin
                        rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_done = 1'b1;
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rx_state  <= RX_IDLE;
            rx_timer  <= '0;
            rx_bit    <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state <= rx_next;
            // Idle keeps the half-bit count preloaded so the first sample
            // lands mid start bit.
            if (rx_state == RX_IDLE) begin
                rx_timer <= half_bit(div_q);
            end else if (rx_tick) begin
                rx_timer <= div_q;
            end else begin
                rx_timer <= rx_timer - 16'd1;
            end
            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end else if (rx_shift) begin
                rx_bit <= rx_bit + 3'd1;
            end
            if (rx_done) begin
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            // A read on the delivery edge frees the holding register in time.
            if (rx_done && rx_valid && !rd_data) begin
                overrun <= 1'b1;
            end else if (wr_stat && din[3]) begin
                overrun <= 1'b0;
            end
            if (rx_done && !rxd_p1) begin
                frame_err <= 1'b1;
            end else if (wr_stat && din[4]) begin
                frame_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_shift) begin
            rx_sh <= {rxd_p1, rx_sh[7:1]};
        end
        if (rx_done) begin
            rx_byte <= rx_sh;
        end
    end
`else
    logic unused_rxd;

    assign unused_rxd = rxd;
    assign rx_byte    = 8'h00;
    assign rx_valid   = 1'b0;
    assign overrun    = 1'b0;
    assign frame_err  = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    always_comb begin
        dout = 16'h0000;
        if (rnw) begin
            if (sel_data) begin
                dout = {8'h00, rx_byte};
            end else if (sel_stat) begin
                dout = {11'b0, frame_err, overrun, rx_valid, tx_empty, tx_full};
            end else if (sel_div) begin
                dout = div_q;
            end
        end
    end

endmodule

// File: tb/tb_opc5_uart.sv
// -----------------------------------------------------------------------------
// tb_opc5_uart - directed self-checking bench for opc5_uart.
// Inputs change on the falling clock edge; outputs are sampled 1 time unit
// after it, away from the rising edge the design uses.
// -----------------------------------------------------------------------------
module tb_opc5_uart;

    localparam logic [15:0] BASE   = 16'hFE00;
    localparam logic [15:0] A_DATA = BASE;
    localparam logic [15:0] A_STAT = BASE + 16'd1;
    localparam logic [15:0] A_DIV  = BASE + 16'd2;
    localparam logic [15:0] A_NONE = BASE + 16'd3;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [15:0] address;
    logic        rnw;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_en;
    logic        txd;
    logic        rxd;

    int checks = 0;
    int errors = 0;

    opc5_uart #(
        .BASE       (BASE),
        .TX_DEPTH   (4),
        .DEFAULT_DIV(16'd433)
    ) dut (
        .clk    (clk),
        .reset_b(reset_b),
        .address(address),
        .rnw    (rnw),
        .din    (din),
        .dout   (dout),
        .dout_en(dout_en),
        .txd    (txd),
        .rxd    (rxd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the store commits at the next rising edge.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        address = a;
        din     = d;
        rnw     = 1'b0;
        @(negedge clk);
        rnw     = 1'b1;
        address = 16'h0000;
        din     = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        address = a;
        rnw     = 1'b1;
        #1;
        d = dout;
        @(negedge clk);
        address = 16'h0000;
    endtask

    // Combinational look at a register without spending a clock.
    task automatic peek(input logic [15:0] a, output logic [15:0] d);
        address = a;
        rnw     = 1'b1;
        #1;
        d = dout;
    endtask

    // Receive one frame from txd; ok drops on timeout or bad start/stop bit.
    task automatic get_frame(input int bitc, output logic [7:0] b, output logic ok);
        int n;
        ok = 1'b1;
        b  = 8'h00;
        n  = 0;
        while (txd !== 1'b0 && n < 20 * bitc) begin
            @(negedge clk);
            n++;
        end
        if (txd !== 1'b0) ok = 1'b0;
        repeat (bitc / 2) @(negedge clk);
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (bitc) @(negedge clk);
            b[i] = txd;
        end
        repeat (bitc) @(negedge clk);
        if (txd !== 1'b1) ok = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int bitc);
        rxd = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bitc) @(negedge clk);
        end
        rxd = stop;
        repeat (bitc) @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r;
        logic [9:0]  fr;
        logic [7:0]  b;
        logic        ok;
        logic [7:0]  exp4 [5];
        logic [7:0]  exp3 [5];

        exp4[0] = 8'h22; exp4[1] = 8'h33; exp4[2] = 8'h44; exp4[3] = 8'h55; exp4[4] = 8'h66;
        exp3[0] = 8'hA1; exp3[1] = 8'hB2; exp3[2] = 8'hC3; exp3[3] = 8'hD4; exp3[4] = 8'hE5;

        reset_b = 1'b0;
        rnw     = 1'b1;
        address = 16'h0000;
        din     = 16'h0000;
        rxd     = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_txd", {15'b0, txd}, 16'h0001);
        reset_b = 1'b1;
        bus_read(A_STAT, r);
        check_eq("reset_status", r, 16'h0002);
        bus_read(A_DIV, r);
        check_eq("reset_div", r, 16'd433);

        // Decode boundaries
        peek(A_NONE, r);
        check_eq("unmapped_dout", r, 16'h0000);
        check_eq("unmapped_en", {15'b0, dout_en}, 16'h0000);
        address = A_DIV;
        din     = 16'd433;
        rnw     = 1'b0;
        #1;
        check_eq("store_cycle_en", {15'b0, dout_en}, 16'h0000);
        check_eq("store_cycle_dout", dout, 16'h0000);
        @(negedge clk);
        rnw = 1'b1;
        bus_write(A_NONE, 16'h1234);
        bus_read(A_DIV, r);
        check_eq("unmapped_write", r, 16'd433);
        bus_write(A_DIV, 16'h0000);
        bus_read(A_DIV, r);
        check_eq("div_zero", r, 16'h0001);

        // Single byte, 4 clocks per bit
        bus_write(A_DIV, 16'd3);
        bus_write(A_DATA, 16'h00A5);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n % 4 == 1) begin
                check_eq($sformatf("tx_bit%0d", n / 4), {15'b0, txd}, {15'b0, fr[n / 4]});
            end
            if (n == 0) begin
                peek(A_STAT, r);
                check_eq("tx_busy", r, 16'h0000);
            end
            if (n == 39) begin
                peek(A_STAT, r);
                check_eq("tx_stop_busy", r, 16'h0000);
            end
        end
        @(negedge clk);
        bus_read(A_STAT, r);
        check_eq("tx_empty_after", r, 16'h0002);

        // Push on the same edge as the STOP->START pop, FIFO full
        bus_write(A_DATA, 16'h0011);
        bus_write(A_DATA, 16'h0022);
        bus_write(A_DATA, 16'h0033);
        bus_write(A_DATA, 16'h0044);
        bus_write(A_DATA, 16'h0055);
        peek(A_STAT, r);
        check_eq("full_after_fill", r, 16'h0001);
        repeat (36) @(negedge clk);
        check_eq("stop_txd", {15'b0, txd}, 16'h0001);
        peek(A_STAT, r);
        check_eq("full_in_stop", r, 16'h0001);
        bus_write(A_DATA, 16'h0066);
        peek(A_STAT, r);
        check_eq("pushpop_count", r, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            get_frame(4, b, ok);
            check_eq($sformatf("pp_frame%0d", i), {7'b0, ok, b}, {8'h01, exp4[i]});
        end
        repeat (4) @(negedge clk);
        bus_read(A_STAT, r);
        check_eq("pp_idle", r, 16'h0002);

        // FIFO full, sixth store dropped
        bus_write(A_DIV, 16'd100);
        for (int i = 0; i < 5; i++) begin
            bus_write(A_DATA, {8'h00, exp3[i]});
        end
        peek(A_STAT, r);
        check_eq("t3_full", r, 16'h0001);
        bus_write(A_DATA, 16'h00F6);
        peek(A_STAT, r);
        check_eq("t3_full_after6", r, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            get_frame(101, b, ok);
            check_eq($sformatf("t3_frame%0d", i), {7'b0, ok, b}, {8'h01, exp3[i]});
        end
        repeat (101) @(negedge clk);
        check_eq("t3_idle_txd", {15'b0, txd}, 16'h0001);
        bus_read(A_STAT, r);
        check_eq("t3_sixth_dropped", r, 16'h0002);

`ifdef OPC5_UART_RX_EN
        // Receive path, 8 clocks per bit
        bus_write(A_DIV, 16'd7);
        send_rx(8'h3C, 1'b1, 8);
        repeat (2) @(negedge clk);
        bus_read(A_STAT, r);
        check_eq("rx_valid", r, 16'h0006);
        bus_read(A_DATA, r);
        check_eq("rx_data", r, 16'h003C);
        bus_read(A_STAT, r);
        check_eq("rx_cleared", r, 16'h0002);
        send_rx(8'h5A, 1'b1, 8);
        send_rx(8'hC3, 1'b1, 8);
        repeat (2) @(negedge clk);
        bus_read(A_STAT, r);
        check_eq("rx_overrun", r, 16'h000E);
        bus_read(A_DATA, r);
        check_eq("rx_overrun_data", r, 16'h00C3);
        bus_write(A_STAT, 16'h0008);
        bus_read(A_STAT, r);
        check_eq("rx_overrun_clr", r, 16'h0002);
        send_rx(8'h81, 1'b0, 8);
        repeat (4) @(negedge clk);
        bus_read(A_STAT, r);
        check_eq("rx_frame_err", r, 16'h0016);
        bus_write(A_STAT, 16'h0010);
        bus_read(A_STAT, r);
        check_eq("rx_frame_clr", r, 16'h0006);
        bus_read(A_DATA, r);
        check_eq("rx_frame_data", r, 16'h0081);
`else
        // Without the receive path rxd has no effect
        bus_write(A_DIV, 16'd7);
        send_rx(8'h3C, 1'b1, 8);
        repeat (2) @(negedge clk);
        bus_read(A_STAT, r);
        check_eq("norx_status", r, 16'h0002);
        bus_read(A_DATA, r);
        check_eq("norx_data", r, 16'h0000);
`endif

        // Reset in the middle of a frame
        bus_write(A_DIV, 16'd3);
        bus_write(A_DATA, 16'h0000);
        repeat (10) @(negedge clk);
        check_eq("midframe_txd", {15'b0, txd}, 16'h0000);
        reset_b = 1'b0;
        @(negedge clk);
        check_eq("abort_txd", {15'b0, txd}, 16'h0001);
        reset_b = 1'b1;
        bus_read(A_STAT, r);
        check_eq("abort_status", r, 16'h0002);
        bus_read(A_DIV, r);
        check_eq("abort_div", r, 16'd433);
        repeat (50) @(negedge clk);
        check_eq("abort_quiet_txd", {15'b0, txd}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
